// File: rtl/input_sched_pkg.sv
// Shared constants and state type for the input frame scheduler.
// Builds ROWSxCOLS banks into padded columns.
package input_sched_pkg;

   localparam int ROWS_DEF = 24;
   localparam int COLS_DEF = 32;
   localparam int COL_W    = (ROWS_DEF + 2) * 8;
   localparam int LAST_COL = COLS_DEF + 1;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StEmit,
      StRelease
   } state_e;

   function automatic int col_width(input int rows);
      return (rows + 2) * 8;
   endfunction

   function automatic int last_col(input int cols);
      return cols + 1;
   endfunction

endpackage

// File: rtl/input_col_packer.sv
// Delays the issued row index by the buffer read latency.
// Places each returned byte into its slot of the padded column.
module input_col_packer
   import input_sched_pkg::*;
#(
   parameter int ROWS   = ROWS_DEF,
   parameter int RD_LAT = 1,
   parameter int ROW_W  = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     rd_en_i,
   input  logic [ROW_W-1:0]         rd_row_i,
   input  logic [7:0]               rd_data_i,
   input  logic                     fill_i,
   input  logic [7:0]               fill_pad_i,
   output logic                     last_wr_o,
   output logic [(ROWS+2)*8-1:0]    col_data_o
);

   localparam int ColW = col_width(ROWS);

   logic             vld_q [RD_LAT];
   logic [ROW_W-1:0] row_q [RD_LAT];
   logic [ColW-1:0]  col_q;
   logic             wr_vld;
   logic [ROW_W-1:0] wr_row;

   assign wr_vld     = vld_q[RD_LAT-1];
   assign wr_row     = row_q[RD_LAT-1];
   assign last_wr_o  = wr_vld && (wr_row == ROW_W'(ROWS - 1));
   assign col_data_o = col_q;

   // Reset flushes the pipe so in-flight read data never lands.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < RD_LAT; i++) begin
            vld_q[i] <= 1'b0;
            row_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= rd_en_i;
         row_q[0] <= rd_row_i;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            row_q[i] <= row_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col_q <= '0;
      end else if (fill_i) begin
         col_q <= {(ROWS + 2){fill_pad_i}};
      end else if (wr_vld) begin
         for (int r = 0; r < ROWS; r++) begin
            if (wr_row == ROW_W'(r)) begin
               col_q[ColW-9-8*r -: 8] <= rd_data_i;
            end
         end
      end
   end

endmodule

// File: rtl/input_frame_scheduler.sv
// Streams one buffered bank as COLS+2 padded columns to the PE array,
// then hands the bank back to the writer.
module input_frame_scheduler
   import input_sched_pkg::*;
#(
   parameter int ROWS   = ROWS_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  bank_ready,
   output logic                  bank_release,
   output logic                  rd_en,
   output logic [9:0]            rd_addr,
   input  logic [7:0]            rd_data,
   input  logic [7:0]            pad_value,
   output logic                  col_valid,
   input  logic                  col_ready,
   output logic [(ROWS+2)*8-1:0] col_data,
   output logic [5:0]            col_idx,
   output logic                  frame_done,
   output logic                  busy
);

   localparam int         RowW    = $clog2(ROWS);
   localparam logic [5:0] LastIdx = 6'(last_col(COLS));

   state_e          state_q;
   logic [7:0]      pad_q;
   logic [RowW-1:0] issue_q;
   logic            rd_en_q;
   logic [9:0]      rd_addr_q;
   logic            col_valid_q;
   logic [5:0]      col_idx_q;

   logic            start;
   logic            hs;
   logic            fill;
   logic [7:0]      fill_pad;
   logic            last_wr;

   assign start    = (state_q == StIdle) && en && bank_ready;
   assign hs       = (state_q == StEmit) && col_valid_q && col_ready;
   // Every new column begins as all-pad; fetched rows overwrite the interior.
   assign fill     = start || (hs && (col_idx_q != LastIdx));
   assign fill_pad = start ? pad_value : pad_q;

   assign bank_release = (state_q == StRelease);
   assign busy         = (state_q != StIdle);
   assign frame_done   = hs && (col_idx_q == LastIdx);
   assign rd_en        = rd_en_q;
   assign rd_addr      = rd_addr_q;
   assign col_valid    = col_valid_q;
   assign col_idx      = col_idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         pad_q       <= '0;
         issue_q     <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         col_valid_q <= 1'b0;
         col_idx_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q     <= StEmit;
                  pad_q       <= pad_value;
                  col_idx_q   <= '0;
                  col_valid_q <= 1'b1;
               end
            end
            StFetch: begin
               if (rd_en_q) begin
                  if (issue_q == RowW'(ROWS - 1)) begin
                     rd_en_q   <= 1'b0;
                     rd_addr_q <= '0;
                  end else begin
                     issue_q   <= issue_q + 1'b1;
                     rd_addr_q <= rd_addr_q + 10'(COLS);
                  end
               end
               if (last_wr) begin
                  state_q     <= StEmit;
                  col_valid_q <= 1'b1;
               end
            end
            StEmit: begin
               if (hs) begin
                  if (col_idx_q == LastIdx) begin
                     state_q     <= StRelease;
                     col_valid_q <= 1'b0;
                  end else begin
                     col_idx_q <= col_idx_q + 6'd1;
                     // Right pad column needs no reads and stays valid.
                     if (col_idx_q + 6'd1 != LastIdx) begin
                        state_q     <= StFetch;
                        col_valid_q <= 1'b0;
                        rd_en_q     <= 1'b1;
                        issue_q     <= '0;
                        rd_addr_q   <= 10'(col_idx_q);
                     end
                  end
               end
            end
            StRelease: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   input_col_packer #(
      .ROWS   (ROWS),
      .RD_LAT (RD_LAT),
      .ROW_W  (RowW)
   ) u_packer (
      .clk_i      (clk),
      .rst_i      (rst),
      .rd_en_i    (rd_en_q),
      .rd_row_i   (issue_q),
      .rd_data_i  (rd_data),
      .fill_i     (fill),
      .fill_pad_i (fill_pad),
      .last_wr_o  (last_wr),
      .col_data_o (col_data)
   );

endmodule

// File: tb/tb_input_frame_scheduler.sv
// Bench for input_frame_scheduler: frame-level model with per-cycle compare,
// directed scenarios, and a second RD_LAT=2 instance for latency.
module tb_input_frame_scheduler;

   localparam int ROWS = 24;
   localparam int COLS = 32;
   localparam int LAST = COLS + 1;
   localparam int W    = (ROWS + 2) * 8;
   localparam int LAT  = 1;

   logic          clk = 1'b0;
   logic          rst, en, bank_ready, col_ready;
   logic [7:0]    pad_value;

   logic          bank_release, rd_en, col_valid, frame_done, busy;
   logic [9:0]    rd_addr;
   logic [7:0]    rd_data;
   logic [W-1:0]  col_data;
   logic [5:0]    col_idx;

   logic          bank_release2, rd_en2, col_valid2, frame_done2, busy2;
   logic [9:0]    rd_addr2;
   logic [7:0]    rd_data2;
   logic [W-1:0]  col_data2;
   logic [5:0]    col_idx2;

   always #5 clk = ~clk;

   input_frame_scheduler #(.ROWS(ROWS), .COLS(COLS), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst), .en(en), .bank_ready(bank_ready),
      .bank_release(bank_release), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .pad_value(pad_value), .col_valid(col_valid), .col_ready(col_ready),
      .col_data(col_data), .col_idx(col_idx), .frame_done(frame_done), .busy(busy)
   );

   input_frame_scheduler #(.ROWS(ROWS), .COLS(COLS), .RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .bank_ready(bank_ready),
      .bank_release(bank_release2), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
      .pad_value(pad_value), .col_valid(col_valid2), .col_ready(col_ready),
      .col_data(col_data2), .col_idx(col_idx2), .frame_done(frame_done2), .busy(busy2)
   );

   // Buffers preloaded with mem[a] = a[7:0]; junk when no read is due.
   logic [9:0] a1_q, a2a_q, a2b_q;
   logic       v1_q, v2a_q, v2b_q;
   always @(posedge clk) begin
      a1_q  <= rd_addr;  v1_q  <= rd_en;
      a2a_q <= rd_addr2; v2a_q <= rd_en2;
      a2b_q <= a2a_q;    v2b_q <= v2a_q;
   end
   assign rd_data  = v1_q  ? a1_q[7:0]  : 8'hEE;
   assign rd_data2 = v2b_q ? a2b_q[7:0] : 8'hEE;

   function automatic logic [W-1:0] exp_col(input int idx, input logic [7:0] pad);
      logic [W-1:0] v;
      if (idx == 0 || idx == LAST) return {(ROWS + 2){pad}};
      v = {pad, {(W - 16){1'b0}}, pad};
      for (int r = 0; r < ROWS; r++) v = v | (W'((r * COLS + idx - 1) % 256) << (8 * (ROWS - r)));
      return v;
   endfunction

   // Frame model: column index, cycles until the current column is ready.
   int         m_col = 0, m_wait = 0;
   logic       m_busy = 1'b0, m_rel = 1'b0;
   logic [7:0] m_pad = 8'h00;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_rel <= 1'b0; m_col <= 0; m_wait <= 0; m_pad <= 8'h00;
      end else if (m_rel) begin
         m_rel <= 1'b0;
      end else if (!m_busy) begin
         if (en && bank_ready) begin
            m_busy <= 1'b1; m_col <= 0; m_wait <= 0; m_pad <= pad_value;
         end
      end else if (m_wait > 0) begin
         m_wait <= m_wait - 1;
      end else if (col_ready) begin
         if (m_col == LAST) begin
            m_busy <= 1'b0; m_rel <= 1'b1;
         end else begin
            m_col  <= m_col + 1;
            m_wait <= (m_col + 1 == LAST) ? 0 : ROWS + LAT;
         end
      end
   end

   int c_tot = 0, c_pass = 0;
   task automatic ck_c(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
      c_tot++;
      if (a === e) c_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
   endtask

   logic       e_v, e_rd;
   logic [9:0] e_addr;
   always @(negedge clk) begin
      if (!rst) begin
         e_v    = m_busy && (m_wait == 0);
         e_rd   = m_busy && (m_wait > LAT);
         e_addr = e_rd ? 10'((ROWS + LAT - m_wait) * COLS + m_col - 1) : 10'd0;
         ck_c("busy", W'(busy), W'(m_busy || m_rel));
         ck_c("col_valid", W'(col_valid), W'(e_v));
         ck_c("rd_en", W'(rd_en), W'(e_rd));
         ck_c("rd_addr", W'(rd_addr), W'(e_addr));
         ck_c("bank_release", W'(bank_release), W'(m_rel));
         ck_c("frame_done", W'(frame_done), W'(e_v && col_ready && (m_col == LAST)));
         if (e_v) begin
            ck_c("col_idx", W'(col_idx), W'(m_col));
            ck_c("col_data", col_data, exp_col(m_col, m_pad));
         end
      end
   end

   int hs_cnt = 0, fd_cnt = 0, br_cnt = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (!rst) begin
         if (col_valid && col_ready) hs_cnt <= hs_cnt + 1;
         if (frame_done) fd_cnt <= fd_cnt + 1;
         if (bank_release) br_cnt <= br_cnt + 1;
      end
   end

   // RD_LAT=2 instance: first FETCH entry and first column-1 valid.
   logic         d2_rd_seen = 1'b0, d2_got = 1'b0;
   int           d2_t0 = 0, d2_t1 = 0;
   logic [W-1:0] d2_col = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (!d2_rd_seen && rd_en2) begin
            d2_rd_seen <= 1'b1; d2_t0 <= cyc;
         end
         if (d2_rd_seen && !d2_got && col_valid2 && col_idx2 == 6'd1) begin
            d2_got <= 1'b1; d2_t1 <= cyc; d2_col <= col_data2;
         end
      end
   end

   int d_tot = 0, d_pass = 0;
   task automatic ck_d(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
      d_tot++;
      if (a === e) d_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int           hs_base, fd_base, br_base, n;
   logic [W-1:0] hold_data;
   logic [5:0]   hold_idx;

   initial begin
      rst = 1'b1; en = 1'b0; bank_ready = 1'b0; col_ready = 1'b0; pad_value = 8'h00;
      repeat (3) step();
      ck_d("rst_flags", W'({busy, col_valid, rd_en, bank_release, frame_done}), '0);
      ck_d("rst_addr_idx", W'({rd_addr, col_idx}), '0);
      ck_d("rst_col_data", col_data, '0);
      rst = 1'b0;
      step();

      // Frame 1: everything held ready, pad 0x5A.
      pad_value = 8'h5A; en = 1'b1; bank_ready = 1'b1; col_ready = 1'b1;
      step();
      hs_base = hs_cnt; fd_base = fd_cnt; br_base = br_cnt;
      ck_d("f1_col0_hdr", W'({col_valid, col_idx}), W'(7'b1_000000));
      ck_d("f1_col0_data", col_data, {26{8'h5A}});
      en = 1'b0;
      for (n = 0; n < 400 && !(col_valid && col_idx == 6'd5); n++) step();
      ck_d("f1_col5_seen", W'(col_valid && col_idx == 6'd5), W'(1));
      ck_d("f1_col5_b1", W'(col_data[199:192]), W'(8'h04));
      ck_d("f1_col5_b24", W'(col_data[15:8]), W'(8'hE4));
      ck_d("f1_col5_b0", W'(col_data[207:200]), W'(8'h5A));
      ck_d("f1_col5_b25", W'(col_data[7:0]), W'(8'h5A));
      pad_value = 8'hFF;
      for (n = 0; n < 2000 && !frame_done; n++) step();
      ck_d("f1_done_seen", W'(frame_done), W'(1));
      step();
      ck_d("f1_release", W'(bank_release), W'(1));
      step();
      ck_d("f1_idle", W'({bank_release, busy}), '0);
      ck_d("f1_handshakes", W'(hs_cnt - hs_base), W'(34));
      ck_d("f1_frame_done_cnt", W'(fd_cnt - fd_base), W'(1));
      ck_d("f1_release_cnt", W'(br_cnt - br_base), W'(1));

      ck_d("lat2_col1_seen", W'(d2_got), W'(1));
      ck_d("lat2_delay", W'(d2_t1 - d2_t0), W'(26));
      ck_d("lat2_col1_b24", W'(d2_col[15:8]), W'(8'hE0));
      ck_d("lat2_col1_data", d2_col, exp_col(1, 8'h5A));

      // Frame 2: new pad, stall in column 3.
      en = 1'b1;
      step();
      ck_d("f2_col0_data", col_data, {26{8'hFF}});
      en = 1'b0;
      for (n = 0; n < 400 && !(col_valid && col_idx == 6'd3); n++) step();
      ck_d("f2_col3_seen", W'(col_valid && col_idx == 6'd3), W'(1));
      col_ready = 1'b0;
      hold_data = col_data; hold_idx = col_idx;
      for (int i = 0; i < 10; i++) begin
         step();
         ck_d("stall_data", col_data, hold_data);
         ck_d("stall_idx", W'(col_idx), W'(hold_idx));
         ck_d("stall_valid_rd", W'({col_valid, rd_en}), W'(2'b10));
      end
      col_ready = 1'b1;
      step();
      ck_d("stall_next", W'({col_idx, rd_en, rd_addr}), W'({6'd4, 1'b1, 10'd3}));
      for (n = 0; n < 2000 && !frame_done; n++) step();
      ck_d("f2_done_seen", W'(frame_done), W'(1));
      step(); step();

      // Frame 3: reset during column 17 fetch.
      en = 1'b1;
      step();
      en = 1'b0;
      for (n = 0; n < 1000 && !(rd_en && col_idx == 6'd17); n++) step();
      ck_d("f3_col17_fetch", W'(rd_en && col_idx == 6'd17), W'(1));
      br_base = br_cnt;
      step(); step();
      rst = 1'b1;
      #1;
      ck_d("async_flags", W'({busy, col_valid, rd_en, bank_release, frame_done}), '0);
      ck_d("async_addr_idx", W'({rd_addr, col_idx}), '0);
      ck_d("async_col_data", col_data, '0);
      step();
      rst = 1'b0;
      step(); step();
      ck_d("no_release_on_rst", W'(br_cnt - br_base), '0);
      en = 1'b1;
      step();
      ck_d("restart_col0", W'({col_valid, col_idx}), W'(7'b1_000000));
      ck_d("restart_data", col_data, {26{8'hFF}});
      en = 1'b0;
      repeat (30) step();

      $display("%0d/%0d checks passed", d_pass + c_pass, d_tot + c_tot);
      $finish;
   end

endmodule

// File: doc/input_frame_scheduler.md
INPUT_FRAME_SCHEDULER -- requirements
Module: input_frame_scheduler

Interface
REQ-001 SHALL have parameter ROWS, default 24, meaning image rows per bank.
REQ-002 SHALL have parameter COLS, default 32, meaning image columns per bank.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning buffer read latency in cycles.
REQ-004 SHALL have port clk  input  1  the single clock (all logic on its rising edge).
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port en  input  1  permits starting a new frame.
REQ-007 SHALL have port bank_ready  input  1  high when a complete ROWSxCOLS bank is readable.
REQ-008 SHALL have port bank_release  output  1  one-cycle pulse that returns the bank to the writer (ping-pong switch).
REQ-009 SHALL have port rd_en  output  1  buffer read strobe.
REQ-010 SHALL have port rd_addr  output  10  buffer read address, row*COLS+col.
REQ-011 SHALL have port rd_data  input  8  buffer read data, valid RD_LAT cycles after rd_en.
REQ-012 SHALL have port pad_value  input  8  padding byte.
REQ-013 SHALL have port col_valid  output  1  col_data holds a complete padded column.
REQ-014 SHALL have port col_ready  input  1  PE side accepts the column.
REQ-015 SHALL have port col_data  output  (ROWS+2)*8 = 208  padded column; byte 0 at [207:200].
REQ-016 SHALL have port col_idx  output  6  padded column index 0..COLS+1.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse on acceptance of the last column.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement states IDLE, FETCH, EMIT and RELEASE.
REQ-020 IDLE SHALL go to EMIT with col_idx=0 when en&&bank_ready; pad_value SHALL be latched at that edge and used for the whole frame.
REQ-021 Columns 0 and COLS+1 SHALL be all latched-pad bytes and SHALL enter EMIT directly, with no reads.
REQ-022 For column c in 1..COLS, FETCH SHALL assert rd_en for ROWS consecutive cycles with rd_addr=r*COLS+(c-1), r=0..ROWS-1 ascending.
REQ-023 Returned byte for row r SHALL be written to column byte r+1 ([199-8r -: 8]); bytes 0 and ROWS+1 SHALL be the latched pad.
REQ-024 If FETCH is entered at cycle t, col_valid SHALL rise at t+ROWS+RD_LAT (t+25 at defaults).
REQ-025 In EMIT, col_valid SHALL stay high and col_data/col_idx SHALL stay stable until col_valid&&col_ready.
REQ-026 A handshake SHALL complete in the same cycle col_ready is sampled high with col_valid high; col_ready while col_valid is low SHALL be ignored.
REQ-027 On handshake with col_idx<COLS+1, col_idx SHALL increment and the state SHALL go to FETCH, or to EMIT if the new index is COLS+1.
REQ-028 On handshake with col_idx=COLS+1, frame_done SHALL pulse in that cycle, and the state SHALL go to RELEASE.
REQ-029 RELEASE SHALL last one cycle, pulse bank_release, and return to IDLE.
REQ-030 At least one IDLE cycle SHALL occur between frames; bank_ready asserted during RELEASE SHALL start the next frame from IDLE.
REQ-031 en or bank_ready going low mid-frame SHALL NOT abort the frame; they are sampled only in IDLE.
REQ-032 rd_addr SHALL be 0 whenever rd_en is low.

Reset
REQ-033 While rst is high, the state SHALL be IDLE and col_valid, rd_en, bank_release, frame_done and busy SHALL be 0; rd_addr, col_idx, col_data and the latched pad SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without a bank_release pulse; in-flight read data SHALL be discarded.

Structure
REQ-035 A shared package input_sched_pkg SHALL hold ROWS/COLS defaults, the state enum, the column-width constant ((ROWS+2)*8), and the last-column constant (COLS+1).
REQ-036 A single sub-module, input_col_packer, SHALL own the RD_LAT-delayed row-index pipeline and the byte placement into col_data.

Verification
REQ-037 Reset, then bank_ready=1, en=1, pad=0x5A, col_ready=1 throughout -> 34 handshakes, one frame_done, one bank_release one cycle later.
REQ-038 Buffer preloaded with addr[7:0] -> column 5 bytes 1..24 = (r*32+4)[7:0] and bytes 0 and 25 = 0x5A; column 0 = 26x0x5A.
REQ-039 col_ready held low for 10 cycles in column 3 EMIT -> col_data and col_idx stable, rd_en=0, no column skipped.
REQ-040 pad_value changed mid-frame from 0x5A to 0xFF -> the whole frame still uses 0x5A; the next frame uses 0xFF.
REQ-041 rst pulsed high at column 17 FETCH -> all outputs 0 asynchronously, no bank_release; after release, bank_ready restarts at col_idx 0.
REQ-042 RD_LAT=2 build -> first col_valid for column 1 rises 26 cycles after FETCH entry, with correct byte order.
